// File: rtl/uart_rx_word.sv
// UART 8N1 receiver that also packs consecutive bytes into a LENGTH-bit word.
// The first byte of a word lands in the most significant lane. A bad stop bit
// drops the partial word. Short low pulses on rx are rejected as glitches.
module uart_rx_word #(
    parameter int unsigned LENGTH       = 32,  // multiple of 8
    parameter int unsigned CLKS_PER_BIT = 868  // even, >= 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx,
    output logic [LENGTH-1:0] Q,
    output logic              word_valid,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned Bytes = LENGTH / 8;
    localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(Bytes - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [LENGTH-1:0] asm_q, asm_d;
    logic [LENGTH-1:0] q_q, q_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q;
    logic [LENGTH-1:0] word_next;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: frame sequencing, byte capture and word assembly.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        q_d          = q_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        word_next    = asm_q;

        case (state_q)
            StIdle: begin
                // enable only gates new frames; one in flight always completes
                if (enable && !rx_s_q) begin
                    state_d = StStart;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (baud_q == HalfLast) begin
                    baud_d = '0;
                    if (!rx_s_q) begin
                        state_d = StData;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;  // start bit did not hold: glitch
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_q == BitLast) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_q == BitLast) begin
                    // Leave at mid-stop-bit so a back-to-back start edge is caught.
                    baud_d  = '0;
                    state_d = StIdle;
                    if (rx_s_q) begin
                        for (int unsigned i = 0; i < Bytes; i++) begin
                            if (idx_q == IdxW'(Bytes - 1 - i)) begin
                                word_next[i*8 +: 8] = shift_q;
                            end
                        end
                        asm_d        = word_next;
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                        if (idx_q == IdxLast) begin
                            q_d          = word_next;
                            word_valid_d = 1'b1;
                            idx_d        = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;  // drop the partial word
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            q_q          <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            q_q          <= q_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= (state_d != StIdle);
        end
    end

    assign Q          = q_q;
    assign word_valid = word_valid_q;
    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word with CLKS_PER_BIT=8, LENGTH=32.
module tb_uart_rx_word;

    localparam int unsigned LENGTH = 32;
    localparam int unsigned CPB    = 8;
    localparam int          BIT_T  = 80;  // one bit period in time units (clk period 10)

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              rx;
    logic [LENGTH-1:0] Q;
    logic              word_valid;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              frame_err;
    logic              busy;

    uart_rx_word #(
        .LENGTH       (LENGTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx         (rx),
        .Q          (Q),
        .word_valid (word_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected per-byte result from the model.
    typedef struct {
        logic [7:0]  data;
        logic        wv;
        logic [31:0] word;
    } exp_t;

    // Output event observed on the DUT.
    typedef struct {
        logic        bv;
        logic        wv;
        logic        fe;
        logic [7:0]  b;
        logic [31:0] q;
    } obs_t;

    // Stimulus table record.
    typedef struct {
        logic        glitch;
        logic [7:0]  data;
        logic        stop;
        logic [7:0]  exp_byte;
        logic [31:0] exp_q;
    } vec_t;

    exp_t        exp_q[$];
    obs_t        obs_q[$];
    vec_t        vecs[13];
    int          busy_cycles = 0;
    int          checks      = 0;
    int          failures    = 0;
    int          err_pending = 0;
    int          m_idx       = 0;
    logic [31:0] m_word      = '0;
    int          b0;

    // Record every output pulse and count busy cycles.
    always @(negedge clk) begin
        obs_t o;
        if (byte_valid || word_valid || frame_err) begin
            o.bv = byte_valid;
            o.wv = word_valid;
            o.fe = frame_err;
            o.b  = byte_out;
            o.q  = Q;
            obs_q.push_back(o);
        end
        if (busy) busy_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: word assembly, MSB lane first; bad stop drops the word.
    task automatic model_push(input logic [7:0] d, input logic stop);
        exp_t e;
        if (!stop) begin
            err_pending++;
            m_idx = 0;
            return;
        end
        m_word[(3 - m_idx)*8 +: 8] = d;
        e.data = d;
        e.wv   = (m_idx == 3);
        e.word = m_word;
        if (m_idx == 3) m_idx = 0;
        else m_idx++;
        exp_q.push_back(e);
    endtask

    // Drive one 8N1 frame; jitter keeps cumulative drift within one 4-unit step.
    task automatic send_byte(input logic [7:0] d, input logic stop, input bit jit,
                             input bit sync, input bit exp_out);
        logic [9:0] bits;
        int prev;
        int j;
        bits = {stop, d, 1'b0};
        prev = 0;
        if (exp_out) model_push(d, stop);
        if (sync) begin
            @(posedge clk);
            #3;
        end
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (!jit) j = 0;
            else if (i % 2 == 0) j = int'($urandom_range(2)) * 4 - 4;
            else j = -prev;
            prev = j;
            #(BIT_T + j);
        end
        rx = 1'b1;
    endtask

    task automatic settle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle timeout busy"}, busy, 0);
        repeat (3) @(negedge clk);
    endtask

    // Compare observed events against the scoreboard.
    task automatic drain(input string tag);
        obs_t o;
        exp_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.fe) begin
                checks++;
                if (err_pending == 0) begin
                    failures++;
                    $display("FAIL %s unexpected frame_err: got 1 expected 0", tag);
                end else begin
                    err_pending--;
                end
            end
            if (o.wv) check({tag, " byte_valid with word_valid"}, o.bv, 1);
            if (o.bv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s unexpected byte_valid: got byte %h expected none", tag, o.b);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " byte_out"}, o.b, e.data);
                    check({tag, " word_valid"}, o.wv, e.wv);
                    if (e.wv) check({tag, " Q"}, o.q, e.word);
                end
            end
        end
        check({tag, " missing byte_valid count"}, exp_q.size(), 0);
        check({tag, " missing frame_err count"}, err_pending, 0);
        exp_q.delete();
        err_pending = 0;
    endtask

    task automatic glitch(input string tag);
        int start;
        int n;
        @(posedge clk);
        #3;
        start = busy_cycles;
        rx = 1'b0;
        #20;
        rx = 1'b1;
        repeat (20) @(negedge clk);
        n = busy_cycles - start;
        check({tag, " glitch busy pulse"}, (n >= 1 && n <= int'(CPB)), 1);
        check({tag, " glitch idle"}, busy, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'hDE, 1'b1, 8'hDE, 32'h0000_0000};
        vecs[1]  = '{1'b0, 8'hAD, 1'b1, 8'hAD, 32'h0000_0000};
        vecs[2]  = '{1'b0, 8'hBE, 1'b1, 8'hBE, 32'h0000_0000};
        vecs[3]  = '{1'b0, 8'hEF, 1'b1, 8'hEF, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 8'h11, 1'b1, 8'h11, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 8'h00, 1'b1, 8'h11, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 8'h22, 1'b1, 8'h22, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 8'h33, 1'b0, 8'h22, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 8'hA1, 1'b1, 8'hA1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 8'h00, 1'b1, 8'hA1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 8'hB2, 1'b1, 8'hB2, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 8'hC3, 1'b1, 8'hC3, 32'hDEAD_BEEF};
        vecs[12] = '{1'b0, 8'hD4, 1'b1, 8'hD4, 32'hA1B2_C3D4};

        rst    = 1'b1;
        enable = 1'b1;
        rx     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset Q", Q, 0);
        check("reset byte_out", byte_out, 0);
        check("reset byte_valid", byte_valid, 0);
        check("reset word_valid", word_valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Word assembly, glitches and framing error from the table.
        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].glitch) begin
                glitch(tag);
            end else begin
                send_byte(vecs[i].data, vecs[i].stop, 1'b0, 1'b1, 1'b1);
                settle(tag);
            end
            drain(tag);
            check({tag, " byte_out held"}, byte_out, vecs[i].exp_byte);
            check({tag, " Q held"}, Q, vecs[i].exp_q);
        end

        // Reset during the data bits of a third byte.
        send_byte(8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        settle("rst pre0");
        send_byte(8'h66, 1'b1, 1'b0, 1'b1, 1'b1);
        settle("rst pre1");
        drain("rst pre");
        @(posedge clk);
        #3;
        rx = 1'b0;
        #(BIT_T * 4);
        @(negedge clk);
        check("rst mid-frame busy before", busy, 1);
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst Q", Q, 0);
        check("rst byte_out", byte_out, 0);
        check("rst busy", busy, 0);
        check("rst byte_valid", byte_valid, 0);
        check("rst word_valid", word_valid, 0);
        check("rst frame_err", frame_err, 0);
        m_idx  = 0;
        m_word = '0;
        repeat (20) @(negedge clk);
        check("rst stays idle", busy, 0);
        drain("rst abort");
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, 1'b0, 1'b1, 1'b1);
            settle("rst word");
        end
        drain("rst word");
        check("rst word Q", Q, 32'h0102_0304);

        // Enable gating.
        enable = 1'b0;
        b0 = busy_cycles;
        send_byte(8'h7E, 1'b1, 1'b0, 1'b1, 1'b0);
        settle("en off");
        check("en off busy cycles", busy_cycles - b0, 0);
        drain("en off");
        check("en off byte_out", byte_out, 8'h04);
        enable = 1'b1;
        fork
            send_byte(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
            begin
                repeat (30) @(negedge clk);
                enable = 1'b0;
            end
        join
        settle("en drop");
        drain("en drop");
        check("en drop byte_out", byte_out, 8'h81);
        enable = 1'b1;
        send_byte(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        send_byte(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        send_byte(8'hF0, 1'b1, 1'b0, 1'b1, 1'b1);
        settle("en resume");
        drain("en resume");
        check("en resume Q", Q, 32'h813C_5AF0);

        // Back-to-back jittered frames.
        send_byte(8'h12, 1'b1, 1'b1, 1'b1, 1'b1);
        send_byte(8'h34, 1'b1, 1'b1, 1'b0, 1'b1);
        send_byte(8'h56, 1'b1, 1'b1, 1'b0, 1'b1);
        send_byte(8'h78, 1'b1, 1'b1, 1'b0, 1'b1);
        settle("b2b");
        drain("b2b");
        check("b2b Q", Q, 32'h1234_5678);
        check("b2b byte_out", byte_out, 8'h78);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
